// File: rtl/jk_flop_bank.sv
// Bank of WIDTH independent bistable cells with a bank-wide JK/SR/T/D mode select.
// Also provides synchronous clear, parallel load and clock enable, a sticky illegal-SR flag and per-bit change pulses.
module jk_flop_bank #(
    parameter int unsigned           WIDTH     = 8,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] err,
    output logic [WIDTH-1:0] changed
);

    typedef enum logic [1:0] {
        MODE_JK = 2'b00,
        MODE_SR = 2'b01,
        MODE_T  = 2'b10,
        MODE_D  = 2'b11
    } mode_e;

    mode_e            mode_sel;
    logic [WIDTH-1:0] cell_next;
    logic [WIDTH-1:0] illegal_sr;
    logic [WIDTH-1:0] err_set;
    logic [WIDTH-1:0] q_next;

    assign mode_sel = mode_e'(mode);

    always_comb begin
        cell_next  = q;
        illegal_sr = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            case (mode_sel)
                MODE_JK: begin
                    case ({j[i], k[i]})
                        2'b10:   cell_next[i] = 1'b1;
                        2'b01:   cell_next[i] = 1'b0;
                        2'b11:   cell_next[i] = ~q[i];
                        default: cell_next[i] = q[i];
                    endcase
                end
                MODE_SR: begin
                    case ({j[i], k[i]})
                        2'b10:   cell_next[i] = 1'b1;
                        2'b01:   cell_next[i] = 1'b0;
                        2'b11: begin
                            cell_next[i]  = q[i];
                            illegal_sr[i] = 1'b1;
                        end
                        default: cell_next[i] = q[i];
                    endcase
                end
                MODE_T:  cell_next[i] = q[i] ^ j[i];
                default: cell_next[i] = j[i];
            endcase
        end
    end

    // The error flag only records illegal SR inputs on edges where the mode update actually runs.
    always_comb begin
        err_set = '0;
        if (!clr && !load && en)
            err_set = illegal_sr;
    end

    always_comb begin
        if (clr)
            q_next = RESET_VAL;
        else if (load)
            q_next = din;
        else if (en)
            q_next = cell_next;
        else
            q_next = q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q       <= RESET_VAL;
            err     <= '0;
            changed <= '0;
        end else begin
            q       <= q_next;
            changed <= q_next ^ q;
            // A new set outranks err_clr on the same edge.
            err     <= (err_clr ? '0 : err) | err_set;
        end
    end

    assign q_n = ~q;

endmodule

// File: tb/tb_jk_flop_bank.sv
// Self-checking bench: an 8-bit bank (RESET_VAL=8'hA5) and a 1-bit bank against a bit-parallel reference model.
`timescale 1ns/1ps
module tb_jk_flop_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, clr, load, err_clr;
    logic [7:0] din, j, k;
    logic [1:0] mode;
    logic [7:0] q, q_n, err, changed;

    logic       b_en, b_clr, b_load, b_err_clr;
    logic       b_din, b_j, b_k;
    logic [1:0] b_mode;
    logic       b_q, b_q_n, b_err, b_changed;

    int errors = 0;
    int checks = 0;
    bit run_cmp = 1'b0;

    always #5 clk = ~clk;

    jk_flop_bank #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .din(din),
        .mode(mode), .j(j), .k(k), .err_clr(err_clr),
        .q(q), .q_n(q_n), .err(err), .changed(changed)
    );

    jk_flop_bank #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
        .clk(clk), .rst(rst), .en(b_en), .clr(b_clr), .load(b_load), .din(b_din),
        .mode(b_mode), .j(b_j), .k(b_k), .err_clr(b_err_clr),
        .q(b_q), .q_n(b_q_n), .err(b_err), .changed(b_changed)
    );

    // Characteristic equations of the four flop types, applied to all bits at once.
    function automatic logic [7:0] cell_f(input logic [1:0] m, input logic [7:0] qq,
                                          input logic [7:0] jj, input logic [7:0] kk);
        case (m)
            2'b00:   return (jj & ~qq) | (~kk & qq);
            2'b01:   return (jj & ~kk) | (qq & ~(jj ^ kk));
            2'b10:   return qq ^ jj;
            default: return jj;
        endcase
    endfunction

    function automatic logic [7:0] next_q(input logic [7:0] rv, input logic c, input logic l,
                                          input logic e, input logic [1:0] m, input logic [7:0] d,
                                          input logic [7:0] jj, input logic [7:0] kk,
                                          input logic [7:0] qq);
        if (c) return rv;
        if (l) return d;
        if (e) return cell_f(m, qq, jj, kk);
        return qq;
    endfunction

    function automatic logic [7:0] next_err(input logic [7:0] er, input logic c, input logic l,
                                            input logic e, input logic ec, input logic [1:0] m,
                                            input logic [7:0] jj, input logic [7:0] kk);
        logic [7:0] set;
        set = (!c && !l && e && m == 2'b01) ? (jj & kk) : 8'h00;
        return (ec ? 8'h00 : er) | set;
    endfunction

    logic [7:0] mq, merr, mch;
    logic       mq1, merr1, mch1;
    logic [7:0] nq, nq1, ne1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq <= 8'hA5; merr <= 8'h00; mch <= 8'h00;
            mq1 <= 1'b0; merr1 <= 1'b0; mch1 <= 1'b0;
        end else begin
            nq   = next_q(8'hA5, clr, load, en, mode, din, j, k, mq);
            mch  <= nq ^ mq;
            mq   <= nq;
            merr <= next_err(merr, clr, load, en, err_clr, mode, j, k);
            nq1  = next_q(8'h00, b_clr, b_load, b_en, b_mode, {7'b0, b_din}, {7'b0, b_j},
                          {7'b0, b_k}, {7'b0, mq1});
            ne1  = next_err({7'b0, merr1}, b_clr, b_load, b_en, b_err_clr, b_mode,
                            {7'b0, b_j}, {7'b0, b_k});
            mch1  <= nq1[0] ^ mq1;
            mq1   <= nq1[0];
            merr1 <= ne1[0];
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp && rst === 1'b1) begin
            chk("m_q", q, mq);
            chk("m_q_n", q_n, ~mq);
            chk("m_err", err, merr);
            chk("m_changed", changed, mch);
            chk("m_q1", {7'b0, b_q}, {7'b0, mq1});
            chk("m_q_n1", {7'b0, b_q_n}, {7'b0, ~mq1});
            chk("m_err1", {7'b0, b_err}, {7'b0, merr1});
            chk("m_changed1", {7'b0, b_changed}, {7'b0, mch1});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_jk(input logic [1:0] m, input logic [7:0] jj, input logic [7:0] kk);
        mode = m; j = jj; k = kk;
    endtask

    initial begin
        rst = 1'b1;
        en = 0; clr = 0; load = 0; err_clr = 0; din = 8'h00; mode = 2'b00; j = 8'h00; k = 8'h00;
        b_en = 0; b_clr = 0; b_load = 0; b_err_clr = 0; b_din = 0; b_j = 0; b_k = 0; b_mode = 2'b00;
        #2 rst = 1'b0;
        #20;
        chk("rst_q", q, 8'hA5);
        chk("rst_q_n", q_n, 8'h5A);
        chk("rst_err", err, 8'h00);
        chk("rst_changed", changed, 8'h00);
        chk("rst_q1", {7'b0, b_q}, 8'h00);
        // rising edge of rst away from the clock edge
        en = 1; set_jk(2'b00, 8'hFF, 8'hFF);
        #1 rst = 1'b1;
        run_cmp = 1'b1;
        step();
        chk("first_edge_q", q, 8'h5A);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_q", q, 8'hA5);
        chk("async_rst_changed", changed, 8'h00);
        #2 rst = 1'b1;
        en = 0; load = 1; din = 8'h00;
        step();
        chk("load0_q", q, 8'h00);
        chk("load0_changed", changed, 8'hA5);
        load = 0;

        // JK truth table
        en = 1; set_jk(2'b00, 8'h0F, 8'h00); step();
        chk("jk1_q", q, 8'h0F); chk("jk1_changed", changed, 8'h0F);
        set_jk(2'b00, 8'hFF, 8'hFF); step();
        chk("jk2_q", q, 8'hF0); chk("jk2_changed", changed, 8'hFF);
        set_jk(2'b00, 8'h00, 8'h00); step();
        chk("jk3_q", q, 8'hF0); chk("jk3_changed", changed, 8'h00);

        // SR with illegal input and err_clr interaction
        load = 1; din = 8'h00; step(); load = 0;
        set_jk(2'b01, 8'h81, 8'h01); step();
        chk("sr_q", q, 8'h80); chk("sr_err", err, 8'h01);
        err_clr = 1; set_jk(2'b01, 8'h01, 8'h01); step();
        chk("sr_setwins_err", err, 8'h01); chk("sr_hold_q", q, 8'h80);
        set_jk(2'b01, 8'h00, 8'h00); step();
        chk("sr_errclr_err", err, 8'h00);
        err_clr = 0;

        // T then D
        load = 1; din = 8'h00; step(); load = 0;
        set_jk(2'b10, 8'h33, 8'hAA); step();
        chk("t1_q", q, 8'h33); chk("t1_changed", changed, 8'h33);
        step();
        chk("t2_q", q, 8'h00); chk("t2_changed", changed, 8'h33);
        set_jk(2'b11, 8'hC3, 8'hFF); step();
        chk("d_q", q, 8'hC3);

        // priority clr > load > en > hold
        clr = 1; load = 1; en = 1; din = 8'h11; step();
        chk("prio_clr_q", q, 8'hA5);
        clr = 0; load = 1; en = 0; step();
        chk("prio_load_q", q, 8'h11);
        load = 0; en = 0; set_jk(2'b00, 8'hFF, 8'hFF); step();
        chk("prio_hold_q", q, 8'h11); chk("prio_hold_changed", changed, 8'h00);

        // 1-bit bank JK sequence 10, 11, 11, 01
        b_en = 1; b_mode = 2'b00;
        b_j = 1; b_k = 0; step(); chk("w1_a", {7'b0, b_q}, 8'h01);
        b_j = 1; b_k = 1; step(); chk("w1_b", {7'b0, b_q}, 8'h00);
        b_j = 1; b_k = 1; step(); chk("w1_c", {7'b0, b_q}, 8'h01);
        b_j = 0; b_k = 1; step(); chk("w1_d", {7'b0, b_q}, 8'h00);

        // mixed traffic on both banks, checked against the model
        for (int n = 0; n < 200; n++) begin
            en      = 1'($urandom_range(0, 3) != 0);
            clr     = 1'($urandom_range(0, 15) == 0);
            load    = 1'($urandom_range(0, 7) == 0);
            err_clr = 1'($urandom_range(0, 5) == 0);
            din     = 8'($urandom);
            mode    = 2'($urandom);
            j       = 8'($urandom);
            k       = 8'($urandom);
            b_en      = 1'($urandom_range(0, 3) != 0);
            b_clr     = 1'($urandom_range(0, 15) == 0);
            b_load    = 1'($urandom_range(0, 7) == 0);
            b_err_clr = 1'($urandom_range(0, 5) == 0);
            b_din     = 1'($urandom);
            b_mode    = 2'($urandom);
            b_j       = 1'($urandom);
            b_k       = 1'($urandom);
            step();
        end
        en = 0; clr = 0; load = 0; err_clr = 0; b_en = 0; b_clr = 0; b_load = 0; b_err_clr = 0;
        step();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jk_flop_bank.md
Name: jk_flop_bank

Overview:
- A parametrised bank of WIDTH independent bistable cells sharing one clock and reset.
- Each cell holds one bit of state. Its next state comes from a per-bit input pair (j, k) under a bank-wide mode select: JK, SR, T or D.
- The bank also supports synchronous clear, parallel load and clock enable.
- Status outputs:
  - a per-bit sticky error flag for illegal SR inputs;
  - a per-bit one-cycle change pulse.
- Used wherever the design needs a register of control flags with mixed set/reset/toggle semantics.

Parameters:
WIDTH, 8, number of cells in the bank
RESET_VAL, 0 (WIDTH bits), value loaded into q on reset and on synchronous clear

Ports:
clk  input  1  rising-edge clock for all state
rst  input  1  asynchronous, active-low reset
en  input  1  clock enable for the mode-driven update
clr  input  1  synchronous clear of q to RESET_VAL
load  input  1  synchronous parallel load
din  input  WIDTH  parallel load data
mode  input  2  00=JK, 01=SR, 10=T, 11=D
j  input  WIDTH  per-bit J / S / T / D input (meaning depends on mode)
k  input  WIDTH  per-bit K / R input; ignored in T and D modes
err_clr  input  1  synchronous clear of err
q  output  WIDTH  cell state (registered)
q_n  output  WIDTH  bitwise complement of q
err  output  WIDTH  sticky per-bit illegal-SR flag (registered)
changed  output  WIDTH  one-cycle pulse per bit that changed on the previous edge (registered)

Behaviour:
- Clock and reset: one clock domain; one clock, asynchronous active-low reset.
- Reset (rst=0), immediate and independent of clk:
  - q=RESET_VAL, q_n=~RESET_VAL, err=0, changed=0.
  - Reset asserted mid-operation overrides everything.
  - The first edge after rst rises performs a normal update.
- Update priority on each rising edge (rst=1): clr > load > en > hold.
  - clr=1: q<=RESET_VAL, regardless of load/en/mode.
  - else load=1: q<=din, regardless of en.
  - else en=1: q<=f(mode, q, j, k), evaluated per bit.
  - else: q holds.
- Per-bit next-state function f:
  - JK: j=0,k=0 hold; j=1,k=0 -> 1; j=0,k=1 -> 0; j=1,k=1 toggle.
  - SR (j=S, k=R): 00 hold; 10 -> 1; 01 -> 0; 11 illegal.
    - Illegal bit: q holds and err[i] is set.
  - T (j=T): j=1 toggle; j=0 hold. k is don't-care.
  - D (j=D): q<=j. k is don't-care.
- err register:
  - err[i] is set only on an edge where en=1, clr=0, load=0, mode=SR and j[i]=k[i]=1.
  - Once set, it stays set until err_clr=1 or reset.
  - If a set and err_clr occur on the same edge, set wins: err[i]=1 after that edge.
  - clr and load do not affect err.
- changed register: on every edge, changed <= q_next XOR q_current, whatever caused the update.
  - changed is high for exactly one cycle after the edge on which the bit changed.
  - A bit that toggles on consecutive edges keeps changed high on consecutive cycles.
- q_n is combinational ~q. It is never X after reset.
- Latency:
  - q, err and changed reflect inputs sampled at edge N immediately after edge N.
  - No pipelining.
- Mode changes take effect on the same edge they are sampled. No mode state is stored.
- Width rules:
  - All per-bit logic is independent; there is no cross-bit interaction.
  - WIDTH=1 must be legal.

Test Plan:
1. Reset: WIDTH=8, RESET_VAL=8'hA5; hold rst=0, then release -> q=8'hA5, q_n=8'h5A, err=0, changed=0. Assert rst=0 asynchronously mid-cycle while en=1, mode=JK -> q returns to 8'hA5 before the next edge.
2. JK truth table: q=8'h00, en=1, mode=00.
   - j=8'h0F, k=8'h00 -> q=8'h0F, changed=8'h0F.
   - Next edge, j=8'hFF, k=8'hFF -> q=8'hF0, changed=8'hFF.
   - Next edge, j=0, k=0 -> q=8'hF0, changed=8'h00.
3. SR illegal: mode=01, q=8'h00; j=8'h81, k=8'h01 -> q=8'h80, err=8'h01.
   - err_clr=1 together with a repeated illegal input on bit0 -> err stays 8'h01.
   - err_clr=1 with j=k=0 -> err=8'h00.
4. T and D modes, en=1:
   - T mode (mode=10), q=8'h00, j=8'h33 for 2 edges -> q=8'h33 then 8'h00, changed=8'h33 both cycles.
   - D mode (mode=11), j=8'hC3, k=8'hFF -> q=8'hC3.
5. Priority:
   - clr=1, load=1, en=1, din=8'h11 -> q=RESET_VAL.
   - clr=0, load=1, en=0, din=8'h11 -> q=8'h11.
   - en=0, load=0, mode=JK, j=8'hFF, k=8'hFF -> q holds.
6. WIDTH=1 instance: run the JK sequence 10, 11, 11, 01 from q=0 -> q=1, 0, 1, 0.
